// File: rtl/ibex_multdiv_arbiter_if.sv
// Requester/response bundle for the shared multdiv arbiter.
// master: the side issuing requests and consuming responses.
// slave:  the arbiter.
// Operator encoding follows ibex md_op_e: 0=MULL 1=MULH 2=DIV 3=REM.
interface ibex_multdiv_arbiter_if #(
    parameter int unsigned NumReq = 2
);
    logic [NumReq-1:0]         req_valid;
    logic [NumReq-1:0]         req_ready;
    logic [NumReq-1:0][1:0]    req_operator;
    logic [NumReq-1:0][1:0]    req_signed_mode;
    logic [NumReq-1:0][31:0]   req_op_a;
    logic [NumReq-1:0][31:0]   req_op_b;

    logic                      resp_valid;
    logic                      resp_id;
    logic [31:0]               resp_result;
    logic                      resp_ready;

    modport master (
        output req_valid, req_operator, req_signed_mode, req_op_a, req_op_b, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result
    );

    modport slave (
        input  req_valid, req_operator, req_signed_mode, req_op_a, req_op_b, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result
    );
endinterface

// File: rtl/ibex_multdiv_arbiter.sv
// Two-requester front end for a single ibex_multdiv_fast instance.
// Round-robin grant, one operation in flight, operands latched and held
// for the whole operation, result buffered until the owner takes it.
module ibex_multdiv_arbiter #(
    parameter int unsigned NumReq  = 2,
    parameter int unsigned LatCntW = 6
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    ibex_multdiv_arbiter_if.slave bus,
    input  logic                  flush_i,
    output logic [1:0]            md_operator_o,
    output logic [1:0]            md_signed_mode_o,
    output logic [31:0]           md_op_a_o,
    output logic [31:0]           md_op_b_o,
    output logic                  md_mult_en_o,
    output logic                  md_div_en_o,
    input  logic                  md_valid_i,
    input  logic [31:0]           md_result_i,
    output logic [LatCntW-1:0]    last_latency_o
);

    localparam logic [1:0] MD_OP_MULL = 2'd0;
    localparam logic [1:0] MD_OP_MULH = 2'd1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e              state;
    logic                rr_ptr;
    logic                winner;
    logic                accept;
    logic                flush_pend;
    logic                owner_id;
    logic                resp_valid;
    logic [31:0]         result;
    logic [LatCntW-1:0]  lat_cnt;
    logic [NumReq-1:0]   req_ready;
    logic                win_is_mul;

    // Grant: rr pointer breaks ties, otherwise the lone valid requester wins.
    always_comb begin
        winner = bus.req_valid[1];
        if (&bus.req_valid) begin
            winner = rr_ptr;
        end
    end

    // Accept happens only in IDLE; reset masks it so nothing slips in on a reset edge.
    assign accept     = (state == IDLE) && !rst_i && (|bus.req_valid);
    assign win_is_mul = (bus.req_operator[winner] == MD_OP_MULL) ||
                        (bus.req_operator[winner] == MD_OP_MULH);

    // Only the grant winner sees ready, and only while idle.
    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[winner] = 1'b1;
        end
    end

    assign bus.req_ready   = req_ready;
    assign bus.resp_valid  = resp_valid;
    assign bus.resp_id     = owner_id;
    assign bus.resp_result = result;

    // Control FSM with registered unit-side outputs and response buffer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state            <= IDLE;
            rr_ptr           <= 1'b0;
            flush_pend       <= 1'b0;
            owner_id         <= 1'b0;
            resp_valid       <= 1'b0;
            result           <= '0;
            lat_cnt          <= '0;
            last_latency_o   <= '0;
            md_operator_o    <= '0;
            md_signed_mode_o <= '0;
            md_op_a_o        <= '0;
            md_op_b_o        <= '0;
            md_mult_en_o     <= 1'b0;
            md_div_en_o      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        md_operator_o    <= bus.req_operator[winner];
                        md_signed_mode_o <= bus.req_signed_mode[winner];
                        md_op_a_o        <= bus.req_op_a[winner];
                        md_op_b_o        <= bus.req_op_b[winner];
                        md_mult_en_o     <= win_is_mul;
                        md_div_en_o      <= !win_is_mul;
                        owner_id         <= winner;
                        rr_ptr           <= ~winner;
                        lat_cnt          <= LatCntW'(1);
                        flush_pend       <= 1'b0;
                        state            <= BUSY;
                    end
                end
                BUSY: begin
                    // Enables stay up through a flush: dropping them mid-op would
                    // stall the unit's internal FSM, so the result is just dropped.
                    if (flush_i) begin
                        flush_pend <= 1'b1;
                    end
                    if (md_valid_i) begin
                        result         <= md_result_i;
                        last_latency_o <= lat_cnt;
                        md_mult_en_o   <= 1'b0;
                        md_div_en_o    <= 1'b0;
                        if (flush_pend || flush_i) begin
                            flush_pend <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            resp_valid <= 1'b1;
                            state      <= RESP;
                        end
                    end else if (lat_cnt != {LatCntW{1'b1}}) begin
                        lat_cnt <= lat_cnt + 1'b1;
                    end
                end
                RESP: begin
                    if (flush_i || bus.resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    resp_valid   <= 1'b0;
                    md_mult_en_o <= 1'b0;
                    md_div_en_o  <= 1'b0;
                    flush_pend   <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/ibex_multdiv_arbiter.md
Name: ibex_multdiv_arbiter

Overview: Shares one ibex_multdiv_fast instance between two requesters: port 0 is the core pipeline and port 1 is the debug/coprocessor path. Each request carries operator, signed mode and operands. The block arbitrates round-robin, registers the winning operands and holds them stable, and drives mult_en/div_en until the unit signals valid. It buffers the result until the requester accepts it, and only one operation is in flight at a time.

Parameters:
NumReq, 2, number of requesters; fixed at 2, one-bit requester ID.
LatCntW, 6, width of the saturating latency counter.

Ports:
clk_i  input  1  clock
rst_i  input  1  reset; synchronous, active-high
req_valid_i  input  [1:0]  per-requester request valid
req_ready_o  output  [1:0]  per-requester accept
req_operator_i  input  2x md_op_e  MD_OP_MULL/MULH/DIV/REM per requester
req_signed_mode_i  input  2x[1:0]  signed_mode per requester
req_op_a_i  input  2x[31:0]  operand A per requester
req_op_b_i  input  2x[31:0]  operand B per requester
resp_valid_o  output  1  response valid
resp_id_o  output  1  requester owning the response
resp_result_o  output  32  result
resp_ready_i  input  1  response accepted
flush_i  input  1  discard the outstanding/pending response
md_operator_o  output  md_op_e  to multdiv unit
md_signed_mode_o  output  [1:0]  to multdiv unit
md_op_a_o  output  [31:0]  to multdiv unit
md_op_b_o  output  [31:0]  to multdiv unit
md_mult_en_o  output  1  mult enable
md_div_en_o  output  1  div enable
md_valid_i  input  1  multdiv valid_o
md_result_i  input  [31:0]  multdiv multdiv_result_o
last_latency_o  output  LatCntW  enable-to-valid cycle count of last completed op, saturating

Behaviour:
- Reset (rst_i=1 at a clock edge) takes effect on any cycle, including mid-operation.
  - State goes to IDLE; round-robin pointer to 0.
  - All outputs go to 0: req_ready_o=0, resp_valid_o=0, resp_id_o=0, resp_result_o=0, md_* =0, last_latency_o=0.
  - The multdiv unit's own FSM is not reset by this block; integration ties its rst_ni to !rst_i.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready_o is combinational: only the grant winner sees ready=1.
  - Winner: if both requesters are valid, the one pointed to by the rr pointer; otherwise the single valid requester.
  - On accept: latch operator, mode, operands and ID; pointer becomes ~winner; go to BUSY.
  - Enables are 0 in IDLE.
- BUSY:
  - md_mult_en_o=1 iff latched operator is MULL or MULH.
  - md_div_en_o=1 iff latched operator is DIV or REM.
  - Never both at once; md_op_*_o are driven from the latch and held constant.
  - Latency counter starts at 1 in the first BUSY cycle and increments, saturating at 2^LatCntW-1.
  - On md_valid_i=1: capture md_result_i into the result register and write the counter into last_latency_o.
    - If the flush-pending flag is clear: go to RESP.
    - If set: clear it and go to IDLE.
  - Enables drop to 0 in the cycle after valid, so the unit always sees at least one idle cycle between operations.
  - md_valid_i outside BUSY is ignored.
- RESP:
  - resp_valid_o=1; resp_id_o and resp_result_o are stable.
  - On resp_ready_i=1: go to IDLE.
  - req_ready_o=0 throughout RESP.
- Latency from accept:
  - First enable cycle is accept+1.
  - resp_valid_o rises the cycle after md_valid_i.
  - Accept-to-next-accept is at least unit latency + 2 cycles.
- flush_i:
  - IDLE: no effect.
  - BUSY: set flush-pending. Enables stay asserted until md_valid_i, because deasserting them mid-op would freeze the unit's FSM. The result is then discarded.
  - RESP: drop the response and go to IDLE next cycle, even if resp_ready_i is also high.
  - A flush in the same cycle as md_valid_i discards that result.
- Simultaneous events:
  - resp_ready_i and new request valids in RESP: the new request is accepted no earlier than the following IDLE cycle.
- Request inputs may change while not ready; only values present at the accept edge are used.
- Invalid/unknown state: go to IDLE.

Test Plan:
1. Req0 MULL a=7 b=6 mode=00 alone -> req_ready_o[0]=1 in the same cycle; md_mult_en_o=1 for 3 cycles; resp_valid_o with id=0, result=42; last_latency_o=3.
2. Both requesters valid at reset exit:
   - req0 MULH a=0x80000000 b=2 mode=11; req1 DIV a=100 b=7 mode=00.
   - Req0 is served first: result 0xFFFFFFFF.
   - Req1 next: result 14. The pointer then favours req0.
3. Req1 DIV a=5 b=0 -> result 0xFFFFFFFF; REM a=0xFFFFFFF9 (-7) b=2 mode=11 -> result 0xFFFFFFFF (-1); md_div_en_o held high throughout.
4. resp_ready_i held 0 for 10 cycles after MULL 3*3 -> resp_valid_o, id and result=9 stable; req_ready_o=0; no enable assertion until the response is accepted.
5. flush_i pulsed mid-DIV (BUSY cycle 5):
   - md_div_en_o stays high until md_valid_i; no resp_valid_o is raised.
   - A request pending at that time is accepted in the following IDLE cycle and completes normally.
6. rst_i asserted mid-DIV (BUSY cycle 10) -> next cycle all outputs 0 and state IDLE; a following MULL 2*3 returns 6 with id matching the requester.
